// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer (MULDIV_ITER_MUL_EN selects iterative shift-add multiply)
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mul_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn_q, sgn_d, mul_q, mul_d, busy_q, busy_d, done_q, done_d;
  logic [63:0] wk_q, wk_d, step, div_step, fix_res, mul_res, res, p;
  logic [32:0] up;
  logic [31:0] mb, q, r;
  logic neg_p, wr;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    mag = (s && v[31]) ? -v : v;
  endfunction

  assign mb = mag(b_q, sgn_q);
  assign up = wk_q[63:31];

  // one restoring-divide step: shift remainder/quotient left, subtract divisor if it fits
  always_comb begin
    div_step = (up >= {1'b0, mb}) ? {up[31:0] - mb, wk_q[30:0], 1'b1} : {up[31:0], wk_q[30:0], 1'b0};
  end

`ifdef MULDIV_ITER_MUL_EN
  localparam logic ITER = 1'b1;
  logic [31:0] ma;
  logic [32:0] sum;
  assign ma = mag(a_q, sgn_q);
  assign mul_res = '0;
  // one shift-add multiply step: add multiplicand on multiplier lsb, shift product right
  always_comb begin
    sum = {1'b0, wk_q[63:32]} + {1'b0, wk_q[0] ? ma : 32'd0};
    step = mul_q ? {sum, wk_q[31:1]} : div_step;
  end
`else
  localparam logic ITER = 1'b0;
  logic [63:0] ea, eb, prod;
  assign step = div_step;
  assign ea = {{32{sgn_q & a_q[31]}}, a_q};
  assign eb = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod = ea * eb;
  if (MUL_LAT == 1) begin : g_comb
    assign mul_res = prod;
  end else begin : g_pipe
    logic [MUL_LAT-2:0][63:0] pipe_q, pipe_d;
    // product pipeline fed from the latched operands; the top stage is valid in the done cycle
    always_comb begin
      pipe_d[0] = prod;
      for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
    end
    // product pipeline registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else pipe_q <= pipe_d;
    end
    assign mul_res = pipe_q[MUL_LAT-2];
  end
`endif

  // sign correction of the iterated magnitudes; divide by zero returns all-ones / dividend
  always_comb begin
    neg_p = sgn_q & (a_q[31] ^ b_q[31]);
    p = neg_p ? -wk_q : wk_q;
    q = neg_p ? -wk_q[31:0] : wk_q[31:0];
    r = (sgn_q & a_q[31]) ? -wk_q[63:32] : wk_q[63:32];
    fix_res = mul_q ? p : (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r, q};
    res = (state_q == FIX) ? fix_res : mul_res;
    wr = done_q & ~flush;
    hi_d = wr ? res[63:32] : hi_wen ? wdata : hi_q;
    lo_d = wr ? res[31:0] : lo_wen ? wdata : lo_q;
  end

  // sequencer next state: flush aborts and blocks start, start only accepted in IDLE with a one-hot op
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    mul_d = mul_q;
    wk_d = wk_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (start && $onehot(mul_control)) begin
        a_d = src_a;
        b_d = src_b;
        sgn_d = mul_control[0] | mul_control[2];
        mul_d = mul_control[0] | mul_control[1];
        cnt_d = '0;
        wk_d = {32'd0, mag(mul_d ? src_b : src_a, sgn_d)};
        state_d = (mul_d && !ITER) ? MUL : DIV;
      end
    end else if (state_q == MUL) begin
      cnt_d = cnt_q + 5'd1;
      state_d = (cnt_q == 5'(MUL_LAT - 1)) ? IDLE : MUL;
    end else if (state_q == DIV) begin
      cnt_d = cnt_q + 5'd1;
      wk_d = step;
      state_d = (cnt_q == 5'd31) ? FIX : DIV;
    end else state_d = IDLE;
    busy_d = state_d != IDLE;
    done_d = (state_d == MUL && cnt_d == 5'(MUL_LAT - 1)) || state_d == FIX;
  end

  // all sequencer state, operands and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      mul_q <= 1'b0;
      wk_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
      mul_q <= mul_d;
      wk_q <= wk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl against an arithmetic reference
module tb_muldiv_ctrl;
  localparam int ML = 2;
`ifdef MULDIV_ITER_MUL_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif
  localparam logic [3:0] MULT = 4'b0001, MULTU = 4'b0010, DIVS = 4'b0100, DIVU = 4'b1000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, hi_wen = 1'b0, lo_wen = 1'b0;
  logic [3:0] mul_control = '0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  muldiv_ctrl #(.MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_control(mul_control), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MULT) begin
      pr = sa * sb;
      return pr;
    end
    if (op == MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == DIVS) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  task automatic set_hilo(input logic [31:0] v);
    hi_wen = 1'b1;
    lo_wen = 1'b1;
    wdata = v;
    @(negedge clk);
    hi_wen = 1'b0;
    lo_wen = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit wen_done, input bit restart);
    logic [63:0] prev, exp;
    int nb, nd, lat;
    bit last;
    prev = {hi, lo};
    exp = (flush_at > 0) ? prev : ref_res(op, a, b);
    lat = (flush_at > 0) ? flush_at : ((op == MULT || op == MULTU) && !ITER) ? ML : 33;
    start = 1'b1;
    mul_control = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    mul_control = 4'($urandom);
    nb = 0;
    nd = 0;
    last = 1'b0;
    while (busy && nb < 200) begin
      nb++;
      if (done) nd++;
      last = done;
      if (nb == 1) check({tag, "_hold"}, {hi, lo}, prev);
      flush = (nb == flush_at);
      lo_wen = wen_done && done;
      wdata = $urandom;
      if (restart && nb == 2) begin
        start = 1'b1;
        mul_control = MULTU;
      end
      @(negedge clk);
      flush = 1'b0;
      lo_wen = 1'b0;
      start = 1'b0;
    end
    check({tag, "_busy"}, 64'(nb), 64'(lat));
    check({tag, "_done"}, 64'(nd), (flush_at > 0) ? 64'd0 : 64'd1);
    if (flush_at == 0) check({tag, "_donelast"}, 64'(last), 64'd1);
    check({tag, "_res"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [31:0] specials [5];
    logic [3:0] bad [4];
    logic [31:0] ra, rb;
    specials = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
    bad = '{4'b0000, 4'b0011, 4'b0101, 4'b1111};
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("mult", MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    run_op("div_m7_2", DIVS, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2, 0, 0, 0);
    run_op("div_7_m2", DIVS, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("divu_5_0", DIVU, 32'd5, 32'd0, 0, 0, 0);
    run_op("div_min_m1", DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("div_m5_0", DIVS, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
    set_hilo(32'hAAAA_AAAA);
    check("mt_aaaa", {hi, lo}, 64'hAAAA_AAAA_AAAA_AAAA);
    run_op("div_flush", DIVS, 32'd100, 32'd3, 10, 0, 0);
    check("flush_idle", 64'(busy), 64'd0);
    run_op("divu_100_3", DIVU, 32'd100, 32'd3, 0, 0, 0);
    set_hilo(32'h5555_5555);
    start = 1'b1;
    mul_control = DIVS;
    src_a = 32'd1000;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", DIVS, 32'd1000, 32'hFFFF_FFF9, 0, 0, 0);
    run_op("restart", DIVU, 32'd77, 32'd5, 0, 0, 1);
    hi_wen = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hi_wen = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    run_op("mtlo_done", MULT, 32'hFFFF_FFF0, 32'd3, 0, 1, 0);
    run_op("mtlo_done_div", DIVS, 32'd9, 32'd4, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      ra = {hi, lo} == 64'd0 ? 32'd1 : hi;
      start = 1'b1;
      mul_control = bad[i];
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
      start = 1'b0;
      check("bad_op_busy", 64'(busy), 64'd0);
      check("bad_op_hi", 64'(hi), 64'(ra == 32'd1 && hi == 32'd0 ? 32'd0 : ra));
    end
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
      run_op("rand", 4'(1 << $urandom_range(0, 3)), ra, rb, 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
